// File: rtl/zcu216_clk_lock_supervisor.sv
// Board clock MMCM lock supervisor.
// Pulses MMCM reset, waits for a debounced lock with timeout and bounded retries,
// then releases the per-domain resets one by one. Lock loss or a soft request
// re-runs the whole sequence.
module zcu216_clk_lock_supervisor #(
    parameter int NUM_CLK             = 4,
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 8,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             mmcm_locked,
    input  logic                             soft_reset_req,
    output logic                             mmcm_rst,
    output logic [NUM_CLK-1:0]               clk_rst,
    output logic                             all_ready,
    output logic                             lock_fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0] retry_count,
    output logic [CNT_W-1:0]                 lock_loss_count,
    output logic [2:0]                       state
);

    localparam int RW       = $clog2(MAX_RETRIES + 1);
    localparam int REL_SPAN = (NUM_CLK - 1) * STAGGER_CYCLES;
    localparam int MAX_A    = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES - 1
                                                                       : LOCK_TIMEOUT_CYCLES - 1;
    localparam int CNT_MAX  = (MAX_A > REL_SPAN) ? MAX_A : REL_SPAN;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int SW       = $clog2(LOCK_STABLE_CYCLES + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] REL_LAST    = CW'(REL_SPAN);
    localparam logic [SW-1:0] STABLE_LAST = SW'(LOCK_STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RESET_MMCM = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_RELEASE    = 3'd2,
        S_RUN        = 3'd3,
        S_FAIL       = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;        // cycles since entry into the current state
    logic [SW-1:0]        stable_q, stable_d;  // consecutive synchronised-lock cycles
    logic [RW-1:0]        retry_q, retry_d;
    logic [CNT_W-1:0]     loss_q, loss_d, loss_sat;
    logic                 mmcm_rst_q, mmcm_rst_d;
    logic [NUM_CLK-1:0]   clk_rst_q, clk_rst_d;
    logic                 all_ready_q, all_ready_d;
    logic                 lock_fail_q, lock_fail_d;
    logic                 sync1_q, sync2_q;
    logic                 locked_s;

    // Two-flop synchroniser for the asynchronous MMCM LOCKED pin
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= mmcm_locked;
            sync2_q <= sync1_q;
        end
    end

    assign locked_s = sync2_q;
    assign loss_sat = (loss_q == {CNT_W{1'b1}}) ? loss_q : loss_q + CNT_W'(1);

    // Sequencer state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RESET_MMCM;
            cnt_q       <= '0;
            stable_q    <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            mmcm_rst_q  <= 1'b1;
            clk_rst_q   <= '1;
            all_ready_q <= 1'b0;
            lock_fail_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            mmcm_rst_q  <= mmcm_rst_d;
            clk_rst_q   <= clk_rst_d;
            all_ready_q <= all_ready_d;
            lock_fail_q <= lock_fail_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they stay registered
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CW'(1);
        stable_d = '0;
        retry_d  = retry_q;
        loss_d   = loss_q;
        case (state_q)
            S_RESET_MMCM: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                if (locked_s) stable_d = stable_q + SW'(1);
                // A stable lock wins over a timeout landing in the same cycle
                if (locked_s && stable_q == STABLE_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    retry_d = retry_q + RW'(1);
                    state_d = (retry_d == RW'(MAX_RETRIES)) ? S_FAIL : S_RESET_MMCM;
                    cnt_d   = '0;
                end
            end
            S_RELEASE: begin
                if (!locked_s) begin
                    state_d = S_RESET_MMCM;
                    cnt_d   = '0;
                    loss_d  = loss_sat;
                end else if (cnt_q == REL_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q;
                if (!locked_s) begin
                    state_d = S_RESET_MMCM;
                    cnt_d   = '0;
                    loss_d  = loss_sat;
                end
            end
            S_FAIL: cnt_d = cnt_q;
            default: begin
                state_d = S_RESET_MMCM;
                cnt_d   = '0;
            end
        endcase

        // Soft restart overrides everything, including a coincident lock loss
        if (soft_reset_req) begin
            state_d  = S_RESET_MMCM;
            cnt_d    = '0;
            stable_d = '0;
            retry_d  = '0;
            loss_d   = loss_q;
        end

        mmcm_rst_d  = (state_d == S_RESET_MMCM) || (state_d == S_FAIL);
        all_ready_d = (state_d == S_RUN);
        lock_fail_d = (state_d == S_FAIL);
        for (int k = 0; k < NUM_CLK; k++) begin
            if (state_d == S_RELEASE) clk_rst_d[k] = (cnt_d < CW'(k * STAGGER_CYCLES));
            else                      clk_rst_d[k] = (state_d != S_RUN);
        end
    end

    assign mmcm_rst        = mmcm_rst_q;
    assign clk_rst         = clk_rst_q;
    assign all_ready       = all_ready_q;
    assign lock_fail       = lock_fail_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;
    assign state           = state_q;

endmodule

// File: tb/tb_zcu216_clk_lock_supervisor.sv
// Bench for the MMCM lock supervisor: directed scenarios plus a random soak,
// all checked against a cycle-level behavioural model of the sequencing rules.
module tb_zcu216_clk_lock_supervisor;

    localparam int NUM_CLK = 4;
    localparam int RSTP    = 4;
    localparam int TO      = 100;
    localparam int STB     = 10;
    localparam int STG     = 2;
    localparam int MAXR    = 2;
    localparam int CW      = 4;
    localparam int RELN    = (NUM_CLK - 1) * STG;
    localparam logic [15:0] RST_VEC = 16'hF800;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mmcm_locked = 1'b0;
    logic       soft_reset_req = 1'b0;
    logic       mmcm_rst;
    logic [3:0] clk_rst;
    logic       all_ready;
    logic       lock_fail;
    logic [1:0] retry_count;
    logic [3:0] lock_loss_count;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: state id, cycles since entry, lock debounce, counters, 2-cycle lock delay
    int m_st, m_age, m_stable, m_retry, m_loss;
    bit d1, d2;

    always #5 clk = ~clk;

    zcu216_clk_lock_supervisor #(
        .NUM_CLK(NUM_CLK), .RST_PULSE_CYCLES(RSTP), .LOCK_TIMEOUT_CYCLES(TO),
        .LOCK_STABLE_CYCLES(STB), .STAGGER_CYCLES(STG), .MAX_RETRIES(MAXR), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .mmcm_locked(mmcm_locked), .soft_reset_req(soft_reset_req),
        .mmcm_rst(mmcm_rst), .clk_rst(clk_rst), .all_ready(all_ready), .lock_fail(lock_fail),
        .retry_count(retry_count), .lock_loss_count(lock_loss_count), .state(state)
    );

    function automatic logic [15:0] pack_obs();
        return {mmcm_rst, clk_rst, all_ready, lock_fail, retry_count, lock_loss_count, state};
    endfunction

    function automatic logic [15:0] pack_exp();
        logic [3:0] cr;
        for (int k = 0; k < NUM_CLK; k++)
            cr[k] = (m_st == 2) ? (m_age < k * STG) : (m_st != 3);
        return {(m_st == 0 || m_st == 4), cr, (m_st == 3), (m_st == 4),
                2'(m_retry), 4'(m_loss), 3'(m_st)};
    endfunction

    task automatic model_enter(input int s);
        m_st = s; m_age = 0; m_stable = 0;
    endtask

    task automatic model_edge(input bit r, input bit lk, input bit sr);
        bit ls, moved;
        if (r) begin
            m_st = 0; m_age = 0; m_stable = 0; m_retry = 0; m_loss = 0; d1 = 0; d2 = 0;
            return;
        end
        ls = d2; d2 = d1; d1 = lk; moved = 0;
        if (sr) begin
            model_enter(0); m_retry = 0;
            return;
        end
        case (m_st)
            0: if (m_age + 1 == RSTP) begin model_enter(1); moved = 1; end
            1: begin
                m_stable = ls ? m_stable + 1 : 0;
                if (m_stable == STB) begin model_enter(2); moved = 1; end
                else if (m_age + 1 == TO) begin
                    m_retry++;
                    model_enter(m_retry == MAXR ? 4 : 0); moved = 1;
                end
            end
            2, 3: begin
                if (!ls) begin
                    if (m_loss < 15) m_loss++;
                    model_enter(0); moved = 1;
                end else if (m_st == 2 && m_age == RELN) begin
                    m_retry = 0; model_enter(3); moved = 1;
                end
            end
            default: ;
        endcase
        if (!moved) m_age++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(rst, mmcm_locked, soft_reset_req);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; mmcm_locked = 1'b0; soft_reset_req = 1'b0;
        repeat (3) tick();
        total++;
        if (pack_obs() !== RST_VEC) begin
            bad++; $display("FAIL reset_values got=%h exp=%h", pack_obs(), RST_VEC);
        end
        total++;
        if (pack_obs() !== pack_exp()) begin
            bad++; $display("FAIL reset_model got=%h exp=%h", pack_obs(), pack_exp());
        end
    endtask

    task automatic test_nominal();
        int hi = 0, rel_c = -1, rdy_c = -1;
        int fall[NUM_CLK];
        for (int k = 0; k < NUM_CLK; k++) fall[k] = -1;
        rst = 1'b0;
        for (int i = 0; i < 50 && mmcm_rst === 1'b1; i++) begin
            hi++;
            tick();
            total++;
            if (pack_obs() !== pack_exp()) begin
                bad++; $display("FAIL nominal_model cyc=%0d got=%h exp=%h", cyc, pack_obs(), pack_exp());
            end
        end
        total++;
        if (hi != RSTP) begin bad++; $display("FAIL nominal_rst_pulse got=%0d exp=%0d", hi, RSTP); end
        for (int i = 0; i < 120 && all_ready !== 1'b1; i++) begin
            if (i == 20) mmcm_locked = 1'b1;
            tick();
            total++;
            if (pack_obs() !== pack_exp()) begin
                bad++; $display("FAIL nominal_model cyc=%0d got=%h exp=%h", cyc, pack_obs(), pack_exp());
            end
            if (state === 3'd2 && rel_c < 0) rel_c = cyc;
            for (int k = 0; k < NUM_CLK; k++) if (clk_rst[k] === 1'b0 && fall[k] < 0) fall[k] = cyc;
            if (all_ready === 1'b1) rdy_c = cyc;
        end
        for (int k = 0; k < NUM_CLK; k++) begin
            total++;
            if (fall[k] - rel_c != k * STG || rel_c < 0) begin
                bad++; $display("FAIL nominal_stagger k=%0d got=%0d exp=%0d", k, fall[k] - rel_c, k * STG);
            end
        end
        total++;
        if (rdy_c - rel_c != RELN + 1 || rdy_c < 0) begin
            bad++; $display("FAIL nominal_ready got=%0d exp=%0d", rdy_c - rel_c, RELN + 1);
        end
        total++;
        if (lock_loss_count !== 4'd0) begin
            bad++; $display("FAIL nominal_loss got=%0d exp=0", lock_loss_count);
        end
    endtask

    task automatic test_glitch();
        int rise_c;
        mmcm_locked = 1'b0; soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        for (int i = 0; i < 50 && state !== 3'd1; i++) begin
            tick();
            total++;
            if (pack_obs() !== pack_exp()) begin
                bad++; $display("FAIL glitch_model cyc=%0d got=%h exp=%h", cyc, pack_obs(), pack_exp());
            end
        end
        for (int i = 0; i < 9; i++) begin
            mmcm_locked = (i < 8);
            tick();
            total++;
            if (pack_obs() !== pack_exp()) begin
                bad++; $display("FAIL glitch_model cyc=%0d got=%h exp=%h", cyc, pack_obs(), pack_exp());
            end
        end
        mmcm_locked = 1'b1;
        rise_c = cyc;
        for (int i = 0; i < 60 && state !== 3'd2; i++) begin
            tick();
            total++;
            if (pack_obs() !== pack_exp()) begin
                bad++; $display("FAIL glitch_model cyc=%0d got=%h exp=%h", cyc, pack_obs(), pack_exp());
            end
        end
        total++;
        if (state !== 3'd2 || cyc - rise_c != STB + 2) begin
            bad++; $display("FAIL glitch_release_time got=%0d state=%0d exp=%0d", cyc - rise_c, state, STB + 2);
        end
        total++;
        if (retry_count !== 2'd0) begin
            bad++; $display("FAIL glitch_retry got=%0d exp=0", retry_count);
        end
    endtask

    task automatic test_release_loss();
        mmcm_locked = 1'b0; soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        for (int i = 0; i < 20 && state !== 3'd1; i++) tick();
        mmcm_locked = 1'b1;
        for (int i = 0; i < 60 && state !== 3'd2; i++) begin
            tick();
            total++;
            if (pack_obs() !== pack_exp()) begin
                bad++; $display("FAIL relloss_model cyc=%0d got=%h exp=%h", cyc, pack_obs(), pack_exp());
            end
        end
        tick();
        mmcm_locked = 1'b0;
        tick();
        total++;
        if (clk_rst !== 4'b1100 || state !== 3'd2) begin
            bad++; $display("FAIL relloss_partial got=%b/%0d exp=1100/2", clk_rst, state);
        end
        mmcm_locked = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (pack_obs() !== pack_exp()) begin
                bad++; $display("FAIL relloss_model cyc=%0d got=%h exp=%h", cyc, pack_obs(), pack_exp());
            end
        end
        total++;
        if (state !== 3'd0 || clk_rst !== 4'hF || all_ready !== 1'b0 || lock_loss_count !== 4'd1) begin
            bad++; $display("FAIL relloss_reassert got=%0d/%h/%0d exp=0/F/1", state, clk_rst, lock_loss_count);
        end
    endtask

    task automatic test_soft_coincident();
        mmcm_locked = 1'b1;
        for (int i = 0; i < 100 && all_ready !== 1'b1; i++) begin
            tick();
            total++;
            if (pack_obs() !== pack_exp()) begin
                bad++; $display("FAIL softco_model cyc=%0d got=%h exp=%h", cyc, pack_obs(), pack_exp());
            end
        end
        mmcm_locked = 1'b0;
        tick();
        mmcm_locked = 1'b1;
        tick();
        total++;
        if (state !== 3'd3) begin bad++; $display("FAIL softco_prerun got=%0d exp=3", state); end
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        total++;
        if (state !== 3'd0 || lock_loss_count !== 4'd1 || clk_rst !== 4'hF || all_ready !== 1'b0) begin
            bad++; $display("FAIL softco_restart got=%0d/%0d/%h exp=0/1/F", state, lock_loss_count, clk_rst);
        end
        tick();
        total++;
        if (pack_obs() !== pack_exp()) begin
            bad++; $display("FAIL softco_model cyc=%0d got=%h exp=%h", cyc, pack_obs(), pack_exp());
        end
    endtask

    task automatic test_timeout_fail();
        int seg = 0, seglen = 0, waitc = 0;
        bit in_seg = 0;
        int lens[4], retr[4];
        for (int k = 0; k < 4; k++) begin lens[k] = 0; retr[k] = -1; end
        mmcm_locked = 1'b0; soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        for (int i = 0; i < 400 && state !== 3'd4; i++) begin
            if (state === 3'd0) begin
                if (!in_seg) begin in_seg = 1; if (seg < 4) retr[seg] = retry_count; end
                seglen++;
            end else if (in_seg) begin
                if (seg < 4) lens[seg] = seglen;
                seg++; seglen = 0; in_seg = 0;
            end
            if (state === 3'd1) waitc++;
            tick();
            total++;
            if (pack_obs() !== pack_exp()) begin
                bad++; $display("FAIL timeout_model cyc=%0d got=%h exp=%h", cyc, pack_obs(), pack_exp());
            end
        end
        total++;
        if (seg != 2 || lens[0] != RSTP || lens[1] != RSTP) begin
            bad++; $display("FAIL timeout_pulses got=%0d:%0d,%0d exp=2:%0d,%0d", seg, lens[0], lens[1], RSTP, RSTP);
        end
        total++;
        if (retr[0] != 0 || retr[1] != 1 || waitc != 2 * TO) begin
            bad++; $display("FAIL timeout_retry got=%0d,%0d wait=%0d exp=0,1 wait=%0d", retr[0], retr[1], waitc, 2 * TO);
        end
        total++;
        if (state !== 3'd4 || lock_fail !== 1'b1 || mmcm_rst !== 1'b1 || clk_rst !== 4'hF || retry_count !== 2'd2) begin
            bad++; $display("FAIL timeout_fail_outputs got=%h exp=st4 fail1 rst1 F retry2", pack_obs());
        end
        mmcm_locked = 1'b1;
        repeat (30) tick();
        total++;
        if (state !== 3'd4) begin bad++; $display("FAIL fail_sticky got=%0d exp=4", state); end
        soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        total++;
        if (state !== 3'd0 || lock_fail !== 1'b0 || retry_count !== 2'd0 || mmcm_rst !== 1'b1) begin
            bad++; $display("FAIL fail_soft_exit got=%h exp=state0 fail0 retry0", pack_obs());
        end
    endtask

    task automatic test_lock_loss_run();
        int exp;
        mmcm_locked = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 100 && all_ready !== 1'b1; i++) begin
                tick();
                total++;
                if (pack_obs() !== pack_exp()) begin
                    bad++; $display("FAIL runloss_model cyc=%0d got=%h exp=%h", cyc, pack_obs(), pack_exp());
                end
            end
            mmcm_locked = 1'b0;
            tick();
            mmcm_locked = 1'b1;
            tick();
            tick();
            exp = (n + 2 > 15) ? 15 : n + 2;
            total++;
            if (state !== 3'd0 || clk_rst !== 4'hF || all_ready !== 1'b0 || lock_loss_count !== 4'(exp)) begin
                bad++; $display("FAIL runloss n=%0d got=%0d/%h/%0d exp=0/F/%0d", n, state, clk_rst, lock_loss_count, exp);
            end
        end
    endtask

    task automatic test_rst_mid_wait();
        mmcm_locked = 1'b0; soft_reset_req = 1'b1;
        tick();
        soft_reset_req = 1'b0;
        for (int i = 0; i < 20 && state !== 3'd1; i++) tick();
        repeat (5) tick();
        rst = 1'b1;
        tick();
        total++;
        if (pack_obs() !== RST_VEC) begin
            bad++; $display("FAIL rst_mid_wait got=%h exp=%h", pack_obs(), RST_VEC);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                mmcm_locked = ($urandom_range(0, 3) != 0);
                if (mmcm_locked) hold = $urandom_range(1, 80);
                else hold = ($urandom_range(0, 7) == 0) ? $urandom_range(90, 250) : $urandom_range(1, 15);
            end
            hold--;
            soft_reset_req = ($urandom_range(0, 199) == 0);
            rst = ($urandom_range(0, 999) == 0);
            tick();
            total++;
            if (pack_obs() !== pack_exp()) begin
                bad++; $display("FAIL random_model cyc=%0d got=%h exp=%h", cyc, pack_obs(), pack_exp());
            end
        end
        rst = 1'b0; soft_reset_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_glitch();
        test_release_loss();
        test_soft_coincident();
        test_timeout_fail();
        test_lock_loss_run();
        test_rst_mid_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
